// File: rtl/piso_serializer_pkg.sv
// Shared link constants for the serial transmit path: FSM encodings,
// the default link width and the bit-order selector value.
package piso_serializer_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int DEFAULT_WIDTH = 5;

    localparam logic SIDE_MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter for one serial word: counts 0..WIDTH-1 and flags
// the final position. Clear wins over enable.
module piso_serializer_bit_counter #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic term
);

    logic [CNT_W-1:0] count;

    // NOTE: state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Clearing on the terminal count keeps the counter from passing WIDTH-1.
    assign term = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word on load & ready and
// emits it one bit per clk, MSB-first when side=1, LSB-first otherwise.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             side,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
    output logic             ready,
    output logic             sdata,
    output logic             sen,
    output logic             last
);

    logic [0:0]       state;
    logic [WIDTH-1:0] sreg;
    logic             side_q;
    logic             term;
    logic             shifting;
    logic             accept;

    assign shifting = (state == ST_SHIFT);
    assign last     = shifting & term;
    // Ready during the final bit lets a new word follow with no idle gap.
    assign ready    = ~shifting | term;
    assign accept   = load & ready;
    assign sen      = shifting;
    assign sdata    = shifting & (side_q ? sreg[WIDTH-1] : sreg[0]);

    piso_serializer_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (~shifting | term),
        .en    (shifting),
        .term  (term)
    );

    // NOTE: the shift register is reset too, so an abandoned word leaves no residue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            side_q <= 1'b0;
        end else if (accept) begin
            state  <= ST_SHIFT;
            sreg   <= pdata;
            side_q <= side;
        end else if (shifting) begin
            if (term) begin
                state <= ST_IDLE;
            end
            if (side_q == SIDE_MSB_FIRST) begin
                sreg <= {sreg[WIDTH-2:0], 1'b0};
            end else begin
                sreg <= {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

endmodule
